// File: rtl/lfsr_burst_source.sv
// Burst-controlled pseudo-random word source: a 32-bit Galois LFSR feeds a
// one-entry valid/ready output register, emitting burst_len words per start.
module lfsr_burst_source #(
  parameter int          WIDTH        = 16,
  parameter logic [31:0] POLY         = 32'h80200003,
  parameter logic [31:0] DEFAULT_SEED = 32'h00000001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reseed,
  input  logic [31:0]      seed_val,
  input  logic             start,
  input  logic [15:0]      burst_len,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [31:0]      word_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state, state_nx;
  logic [31:0] lfsr, lfsr_step;
  logic [15:0] remaining, remaining_nx;
  logic        slot_free, hs, load, done_nx;

  assign slot_free = !out_valid || out_ready;
  assign hs        = out_valid && out_ready;
  assign busy      = (state != IDLE);
  assign lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ POLY) : (lfsr >> 1);

  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    load         = 1'b0;
    done_nx      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          remaining_nx = burst_len;
          // A zero-length burst completes immediately without leaving IDLE.
          if (burst_len != 16'd0) state_nx = RUN;
          else                    done_nx  = 1'b1;
        end
      end
      RUN: begin
        if (slot_free) begin
          load         = 1'b1;
          remaining_nx = remaining - 16'd1;
          if (remaining == 16'd1) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (hs) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= DEFAULT_SEED;
      remaining <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      word_cnt  <= '0;
    end else if (reseed) begin
      // Any in-flight word is dropped; a zero seed would lock the LFSR.
      state     <= IDLE;
      lfsr      <= (seed_val == 32'd0) ? DEFAULT_SEED : seed_val;
      remaining <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      word_cnt  <= '0;
    end else begin
      state     <= state_nx;
      remaining <= remaining_nx;
      done      <= done_nx;
      if (hs) word_cnt <= word_cnt + 32'd1;
      if (load) begin
        out_data  <= lfsr[WIDTH-1:0];
        out_valid <= 1'b1;
        lfsr      <= lfsr_step;
      end else if (slot_free) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/lfsr_burst_source.md
# lfsr_burst_source

Pseudo-random word source with a burst controller and a valid/ready output. It generates test and stimulus data from a 32-bit Galois LFSR and emits exactly `burst_len` words per `start` pulse. It sits directly upstream of the bit-order reversal stage (`reverse_vector`) and feeds its `in` port from `out_data`. Its reseed mechanism replaces the free-running `c_rand` source wherever a deterministic, flow-controlled sequence is needed.

## Interface
- `WIDTH`, 16: output word width; legal range 2..32.
- `POLY`, 32'h80200003: Galois feedback mask (x^32+x^22+x^2+x+1).
- `DEFAULT_SEED`, 32'h00000001: LFSR value after reset and on a zero-seed reseed; must be nonzero.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `reseed` in 1: load a new seed and abort any burst.
- `seed_val` in 32: seed, sampled when `reseed` is 1.
- `start` in 1: one-cycle pulse that begins a burst; ignored unless the state is IDLE.
- `burst_len` in 16: number of words in the burst, sampled with `start`.
- `out_data` out WIDTH: generated word.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: downstream accepts the word.
- `busy` out 1: a burst is in progress (state is not IDLE).
- `done` out 1: one-cycle pulse when a burst completes normally.
- `word_cnt` out 32: count of accepted words since the last reset or reseed; wraps modulo 2^32.

## Operation
- **LFSR step:**
  - `lfsr[0]==1`: `lfsr <= (lfsr>>1) ^ POLY`.
  - otherwise: `lfsr <= lfsr>>1`.
  - The LFSR advances only when a word is loaded into the output register.
- **Output register:**
  - The slot is free when `!out_valid || out_ready`.
  - Load in RUN with a free slot: `out_data <= lfsr[WIDTH-1:0]`, `out_valid <= 1`, LFSR steps, `remaining` decrements.
  - A free slot with no load: `out_valid <= 0`.
  - While `out_valid && !out_ready`, `out_data` and the LFSR hold stable.
- **State machine:**
  - IDLE: `start` sets `remaining <= burst_len`.
    - If `burst_len != 0`, go to RUN.
    - If `burst_len == 0`, stay in IDLE and pulse `done` the next cycle; no words are emitted.
  - RUN: load words while the slot is free. Go to DRAIN in the cycle the word with `remaining==1` is loaded.
  - DRAIN: no loads. On a handshake (`out_valid && out_ready`), go to IDLE and pulse `done` in the following cycle.
- `busy` is high in RUN and DRAIN.
- `word_cnt` increments on every handshake.
- **Reseed:** highest priority below `rst`; acts in any state.
  - `lfsr <= (seed_val==0) ? DEFAULT_SEED : seed_val`.
  - State goes to IDLE; `out_valid <= 0` (the pending word is dropped); `word_cnt <= 0`; no `done` pulse.
  - `start` in the same cycle as `reseed` is ignored.
- `start` while `busy` is ignored, and `burst_len` is not resampled.
- **Reset values:** state IDLE, `lfsr = DEFAULT_SEED`, `out_data = 0`, `out_valid = 0`, `busy = 0`, `done = 0`, `word_cnt = 0`, `remaining = 0`.
- The LFSR never reaches zero, because every seed path excludes zero.

## Timing
- `start` sampled at edge k: `busy` is 1 after edge k+1 (RUN); the first `out_valid` is 1 after edge k+2.
- With `out_ready` held at 1: one word per cycle, and N words occupy N consecutive cycles.
- The last handshake at edge m: `busy` is 0 and `done` is 1 after edge m+1; `done` is 0 after edge m+2.
- Back-pressure (`out_ready` low) stalls generation with no loss or duplication of words.
- A `reseed` at edge r takes effect after edge r+1: `out_valid` 0, `busy` 0, `word_cnt` 0.
- `out_data`, `out_valid`, `busy`, `done` and `word_cnt` are all registered. The only combinational input-to-output path is none; `out_ready` affects registers only.

## Test plan
- **Reset sequence:** reset, then `start` with `burst_len=4` and `out_ready=1` -> `out_data` is 0x0001, 0x0003, 0x0002, 0x0001 on consecutive cycles. `done` pulses once, one cycle after the 4th handshake. `word_cnt=4`.
- **Back-pressure:** `burst_len=3`, `out_ready` toggled 1,0,0,1,0,1,... -> exactly 3 handshakes with the same values as an unstalled run. `out_data` is stable while stalled; `done` pulses once.
- **Zero-length burst:** `burst_len=0` -> `done` pulses once and `out_valid` never rises. A zero seed (`reseed` with `seed_val=0`) -> the next first word is 0x0001 (DEFAULT_SEED).
- **Reseed mid-burst:** `burst_len=100`, then `reseed` with `seed_val=32'h0000ABCD` after 10 handshakes -> `out_valid` and `busy` are 0 with no `done` pulse, `word_cnt=0`. The next burst's first word is 0xABCD.
- **Ignored start:** a `start` pulse during a busy burst with a different `burst_len` -> the burst length is unchanged and only one `done` pulse occurs.
- **Synchronous reset mid-burst:** assert `rst` during a stall with `out_valid=1` -> after the next edge all outputs hold their reset values. A burst started afterwards repeats the 0x0001, 0x0003 sequence.
